// File: rtl/sccb_arbiter_if.sv
// rtl/sccb_arbiter_if.sv - requester, SCCB-side and status signals of the SCCB write arbiter
interface sccb_arbiter_if;
   logic       req0_valid;
   logic       req1_valid;
   logic [7:0] req0_addr;
   logic [7:0] req1_addr;
   logic [7:0] req0_data;
   logic [7:0] req1_data;
   logic       lock0;
   logic       req0_acc;
   logic       req1_acc;
   logic       req0_done;
   logic       req1_done;
   logic       req0_err;
   logic       req1_err;
   logic       sccb_ready;
   logic       sccb_start;
   logic [7:0] sccb_addr;
   logic [7:0] sccb_data;
   logic       busy;

   modport master (
      output req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
             lock0, sccb_ready,
      input  req0_acc, req1_acc, req0_done, req1_done, req0_err, req1_err,
             sccb_start, sccb_addr, sccb_data, busy
   );

   modport slave (
      input  req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
             lock0, sccb_ready,
      output req0_acc, req1_acc, req0_done, req1_done, req0_err, req1_err,
             sccb_start, sccb_addr, sccb_data, busy
   );
endinterface

// File: rtl/sccb_arbiter.sv
// rtl/sccb_arbiter.sv - two-port arbiter in front of the SCCB register-write interface
// Port 0 is the boot configuration sequencer, port 1 the runtime tuning writer.
module sccb_arbiter #(
   parameter int unsigned CLK_FREQ      = 25000000,
   parameter int unsigned GAP_CYCLES    = CLK_FREQ / 100000,
   parameter int unsigned START_TIMEOUT = 16,
   parameter int unsigned XFER_TIMEOUT  = CLK_FREQ / 1000
) (
   input  logic            clk,
   input  logic            resetn,
   sccb_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] gap_q, gap_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        start_q, start_d;
   logic [1:0]  acc_q, acc_d;
   logic [1:0]  done_q, done_d;
   logic [1:0]  err_q, err_d;
   logic        win;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      data_d  = data_q;
      start_d = 1'b0;
      acc_d   = 2'b00;
      done_d  = 2'b00;
      err_d   = 2'b00;
      win     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.sccb_ready && (bus.req0_valid || bus.req1_valid)) begin
               // Under contention lock0 pins port 0, otherwise alternate away from the last grant.
               if (bus.req0_valid && bus.req1_valid)
                  win = bus.lock0 ? 1'b0 : ~last_q;
               else
                  win = bus.req1_valid;
               addr_d     = win ? bus.req1_addr : bus.req0_addr;
               data_d     = win ? bus.req1_data : bus.req0_data;
               start_d    = 1'b1;
               acc_d[win] = 1'b1;
               owner_d    = win;
               last_d     = win;
               timer_d    = 32'd0;
               state_d    = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!bus.sccb_ready) begin
               timer_d = 32'd0;
               state_d = WAIT_DONE;
            end else if (timer_q >= START_TIMEOUT) begin
               err_d[owner_q] = 1'b1;
               gap_d          = GAP_CYCLES;
               state_d        = GAP;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         WAIT_DONE: begin
            // Ready returning wins over a timeout reached on the same edge.
            if (bus.sccb_ready) begin
               done_d[owner_q] = 1'b1;
               gap_d           = GAP_CYCLES;
               state_d         = GAP;
            end else if (timer_q >= XFER_TIMEOUT) begin
               err_d[owner_q] = 1'b1;
               gap_d          = GAP_CYCLES;
               state_d        = GAP;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         GAP: begin
            if (gap_q <= 32'd1)
               state_d = IDLE;
            else
               gap_d = gap_q - 32'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         timer_q <= 32'd0;
         gap_q   <= 32'd0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= 8'd0;
         data_q  <= 8'd0;
         start_q <= 1'b0;
         acc_q   <= 2'b00;
         done_q  <= 2'b00;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         gap_q   <= gap_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         start_q <= start_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.sccb_start = start_q;
   assign bus.sccb_addr  = addr_q;
   assign bus.sccb_data  = data_q;
   assign bus.req0_acc   = acc_q[0];
   assign bus.req1_acc   = acc_q[1];
   assign bus.req0_done  = done_q[0];
   assign bus.req1_done  = done_q[1];
   assign bus.req0_err   = err_q[0];
   assign bus.req1_err   = err_q[1];
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sccb_arbiter.sv
// tb/tb_sccb_arbiter.sv - self-checking bench for sccb_arbiter
// Grant table plus hand-written timeout and reset sequences against a grant/completion scoreboard.
module tb_sccb_arbiter;
   localparam int unsigned GAP   = 4;
   localparam int unsigned ST_TO = 16;
   localparam int unsigned XF_TO = 100;

   typedef struct {
      logic       v0, v1, lock0;
      logic [7:0] a0, d0, a1, d1;
      logic       exp_port;
   } vec_t;
   typedef struct { logic port; logic [7:0] addr; logic [7:0] data; } grant_t;
   typedef struct { logic port; logic is_err; } comp_t;

   logic clk;
   logic resetn;
   sccb_arbiter_if bus();

   sccb_arbiter #(
      .CLK_FREQ(25000000), .GAP_CYCLES(GAP), .START_TIMEOUT(ST_TO), .XFER_TIMEOUT(XF_TO)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   int checks = 0, errors = 0, cyc = 0;
   int acc_cnt = 0, comp_cnt = 0, done0_cnt = 0;
   int start_cyc = 0, done_cyc = 0, err_cyc = 0, rise_cyc = 0;
   int mode = 0, low_cycles = 3;
   bit hold_low = 0, expect_err = 0;
   grant_t exp_q[$];
   comp_t  comp_q[$];
   vec_t   tbl[11];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name, input string act, input string req);
      checks++;
      errors++;
      $display("FAIL %s actual=%s required=%s", name, act, req);
   endtask

   // which: 0 = any acc, 1 = any done/err, 2 = busy low
   task automatic wait_sig(input int which, input int budget, input string name);
      bit hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         case (which)
            0:       hit = bus.req0_acc | bus.req1_acc;
            1:       hit = bus.req0_done | bus.req1_done | bus.req0_err | bus.req1_err;
            default: hit = !bus.busy;
         endcase
      end
      if (!hit) fail(name, "timeout", "event");
      #1;
   endtask

   function automatic vec_t mk(input logic v0, input logic v1, input logic lk,
                               input int idx, input logic ep);
      vec_t v;
      v.v0 = v0; v.v1 = v1; v.lock0 = lk; v.exp_port = ep;
      v.a0 = 8'(32'h20 + idx); v.d0 = 8'(32'hA0 + idx);
      v.a1 = 8'(32'h40 + idx); v.d1 = 8'(32'hC0 + idx);
      return v;
   endfunction

   // SCCB interface model: drops ready after seeing start, returns it per mode.
   initial begin
      bus.sccb_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.sccb_start && mode != 1) begin
            bus.sccb_ready = 1'b0;
            if (mode == 2) begin
               while (hold_low) @(negedge clk);
            end else begin
               repeat (low_cycles) @(negedge clk);
            end
            bus.sccb_ready = 1'b1;
            rise_cyc = cyc;
         end
      end
   end

   initial begin
      grant_t g;
      comp_t  c;
      forever begin
         @(negedge clk);
         if (bus.req0_acc || bus.req1_acc) begin
            acc_cnt++;
            start_cyc = cyc;
            chk("acc_one_hot", 32'(bus.req0_acc & bus.req1_acc), 32'd0);
            chk("start_with_acc", 32'(bus.sccb_start), 32'd1);
            if (exp_q.size() == 0) begin
               fail("unexpected_acc", "acc", "none");
            end else begin
               g = exp_q.pop_front();
               chk("grant_port", 32'(bus.req1_acc), 32'(g.port));
               chk("grant_addr", 32'(bus.sccb_addr), 32'(g.addr));
               chk("grant_data", 32'(bus.sccb_data), 32'(g.data));
            end
            comp_q.push_back('{port: bus.req1_acc, is_err: expect_err});
         end else begin
            chk("start_without_acc", 32'(bus.sccb_start), 32'd0);
         end
         if (bus.req0_done || bus.req1_done || bus.req0_err || bus.req1_err) begin
            comp_cnt++;
            chk("completion_one_hot",
                32'($countones({bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err})), 32'd1);
            if (bus.req0_done) done0_cnt++;
            if (bus.req0_err || bus.req1_err) err_cyc = cyc;
            else done_cyc = cyc;
            if (comp_q.size() == 0) begin
               fail("unexpected_completion", "pulse", "none");
            end else begin
               c = comp_q.pop_front();
               chk("completion_port", 32'(bus.req1_done | bus.req1_err), 32'(c.port));
               chk("completion_is_err", 32'(bus.req0_err | bus.req1_err), 32'(c.is_err));
            end
         end
      end
   end

   initial begin
      #500000;
      fail("watchdog", "hang", "finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, a, c0;
      bus.req0_valid = 0; bus.req1_valid = 0; bus.lock0 = 0;
      bus.req0_addr = 0; bus.req0_data = 0; bus.req1_addr = 0; bus.req1_data = 0;
      resetn = 0;
      repeat (3) @(negedge clk);
      chk("reset_pulses", 32'({bus.sccb_start, bus.req0_acc, bus.req1_acc, bus.req0_done,
                              bus.req1_done, bus.req0_err, bus.req1_err}), 32'd0);
      chk("reset_addr", 32'(bus.sccb_addr), 32'd0);
      chk("reset_data", 32'(bus.sccb_data), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      resetn = 1;
      @(negedge clk);

      tbl[0]  = mk(1, 1, 0, 0, 0);
      tbl[1]  = mk(1, 1, 0, 1, 1);
      tbl[2]  = mk(1, 1, 0, 2, 0);
      tbl[3]  = mk(1, 1, 0, 3, 1);
      tbl[4]  = mk(1, 1, 1, 4, 0);
      tbl[5]  = mk(1, 1, 1, 5, 0);
      tbl[6]  = mk(1, 1, 1, 6, 0);
      tbl[7]  = mk(1, 1, 1, 7, 0);
      tbl[8]  = mk(1, 1, 0, 8, 1);
      tbl[9]  = mk(1, 0, 0, 9, 0);
      tbl[10] = mk(0, 1, 1, 10, 1);

      mode = 0; low_cycles = 3; expect_err = 0;
      foreach (tbl[i]) begin
         bus.req0_valid = tbl[i].v0; bus.req1_valid = tbl[i].v1; bus.lock0 = tbl[i].lock0;
         bus.req0_addr = tbl[i].a0; bus.req0_data = tbl[i].d0;
         bus.req1_addr = tbl[i].a1; bus.req1_data = tbl[i].d1;
         exp_q.push_back('{port: tbl[i].exp_port,
                           addr: tbl[i].exp_port ? tbl[i].a1 : tbl[i].a0,
                           data: tbl[i].exp_port ? tbl[i].d1 : tbl[i].d0});
         wait_sig(0, 20, "tbl_acc");
         wait_sig(1, 50, "tbl_done");
         wait_sig(2, 20, "tbl_idle");
      end
      bus.req0_valid = 0; bus.req1_valid = 0; bus.lock0 = 0;

      // Single request, ready low for 40 cycles.
      low_cycles = 40;
      bus.req0_valid = 1; bus.req0_addr = 8'h12; bus.req0_data = 8'h80;
      exp_q.push_back('{port: 1'b0, addr: 8'h12, data: 8'h80});
      a = done0_cnt;
      @(negedge clk);
      chk("single_start", 32'(bus.sccb_start), 32'd1);
      chk("single_acc0", 32'(bus.req0_acc), 32'd1);
      chk("single_addr", 32'(bus.sccb_addr), 32'h12);
      chk("single_data", 32'(bus.sccb_data), 32'h80);
      #1 bus.req0_valid = 0;
      wait_sig(1, 80, "single_done");
      chk("single_done_latency", 32'(done_cyc - rise_cyc), 32'd1);
      n = 0;
      while (bus.busy && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("single_gap_busy_cycles", 32'(n), 32'(GAP));
      chk("single_done_once", 32'(done0_cnt - a), 32'd1);

      // Start timeout: ready never drops. WAIT_BUSY evaluates timer 0..16, err 17 cycles after start.
      mode = 1; expect_err = 1;
      bus.req1_valid = 1; bus.req1_addr = 8'h33; bus.req1_data = 8'h44;
      exp_q.push_back('{port: 1'b1, addr: 8'h33, data: 8'h44});
      wait_sig(0, 20, "st_to_acc");
      bus.req1_valid = 0;
      wait_sig(1, 40, "st_to_err");
      chk("st_to_latency", 32'(err_cyc - start_cyc), 32'(ST_TO + 1));
      wait_sig(2, 20, "st_to_idle");
      chk("st_to_idle_busy", 32'(bus.busy), 32'd0);

      // Transfer timeout: 1 WAIT_BUSY cycle, then WAIT_DONE evaluates timer 0..100.
      mode = 2; hold_low = 1; expect_err = 1;
      bus.req0_valid = 1; bus.req0_addr = 8'h55; bus.req0_data = 8'h66;
      exp_q.push_back('{port: 1'b0, addr: 8'h55, data: 8'h66});
      wait_sig(0, 20, "xf_to_acc");
      bus.req0_valid = 0;
      wait_sig(1, 150, "xf_to_err");
      chk("xf_to_latency", 32'(err_cyc - start_cyc), 32'(XF_TO + 2));
      wait_sig(2, 20, "xf_to_idle");
      bus.req1_valid = 1; bus.req1_addr = 8'h77; bus.req1_data = 8'h88;
      exp_q.push_back('{port: 1'b1, addr: 8'h77, data: 8'h88});
      a = acc_cnt;
      repeat (10) @(negedge clk);
      #1;
      chk("xf_no_grant_ready_low", 32'(acc_cnt - a), 32'd0);
      mode = 0; low_cycles = 3; expect_err = 0; hold_low = 0;
      wait_sig(0, 20, "xf_regrant_acc");
      bus.req1_valid = 0;
      wait_sig(1, 30, "xf_regrant_done");
      wait_sig(2, 20, "xf_regrant_idle");

      // Reset in WAIT_DONE aborts silently; afterwards the tie goes to port 0.
      low_cycles = 40;
      bus.req0_valid = 1; bus.req0_addr = 8'h99; bus.req0_data = 8'hAA;
      exp_q.push_back('{port: 1'b0, addr: 8'h99, data: 8'hAA});
      wait_sig(0, 20, "rst_mid_acc");
      bus.req0_valid = 0;
      repeat (5) @(negedge clk);
      #1 resetn = 0;
      comp_q.delete();
      c0 = comp_cnt;
      @(negedge clk);
      chk("rst_mid_pulses", 32'({bus.sccb_start, bus.req0_acc, bus.req1_acc, bus.req0_done,
                                bus.req1_done, bus.req0_err, bus.req1_err}), 32'd0);
      chk("rst_mid_addr", 32'(bus.sccb_addr), 32'd0);
      chk("rst_mid_data", 32'(bus.sccb_data), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      repeat (45) @(negedge clk);
      #1;
      chk("rst_mid_no_completion", 32'(comp_cnt - c0), 32'd0);
      resetn = 1;
      @(negedge clk);
      #1;
      bus.lock0 = 0;
      bus.req0_valid = 1; bus.req0_addr = 8'hB1; bus.req0_data = 8'hB2;
      bus.req1_valid = 1; bus.req1_addr = 8'hC1; bus.req1_data = 8'hC2;
      low_cycles = 3;
      exp_q.push_back('{port: 1'b0, addr: 8'hB1, data: 8'hB2});
      wait_sig(0, 20, "rst_tie_acc");
      bus.req0_valid = 0; bus.req1_valid = 0;
      wait_sig(1, 30, "rst_tie_done");
      wait_sig(2, 20, "rst_tie_idle");
      chk("scoreboard_drained", 32'(exp_q.size() + comp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
